// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the serial pattern scan controller.
// Holds the FSM state encoding and the pattern length legality check.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int LEN_W = 4;

  function automatic logic len_legal(
    input logic [LEN_W-1:0] len,
    input int               max_len = 8
  );
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/pattern_match_window.sv
// Shift history of the serial stream plus a saturating fill counter.
// hit is combinational and reflects the history after the pending shift.
module pattern_match_window
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               sig,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nx;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   seen;
  logic [LEN_W-1:0]   seen_nx;

  always_comb begin
    hist_nx = {hist[MAX_LEN-2:0], sig};
    seen_nx = seen;
    if (seen != LEN_W'(MAX_LEN))
      seen_nx = seen + LEN_W'(1);
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len));
    hit = shift && (seen_nx >= len) &&
          (((hist_nx ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      seen <= '0;
    end else if (shift) begin
      hist <= hist_nx;
      seen <= seen_nx;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Runs one bounded pattern-detection job over the serial stream.
// Counts overlapping matches within a window of valid bits.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [WIN_W-1:0]   win_in,
  input  logic               sig,
  input  logic               sig_valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
);

  state_t state, nxt;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [WIN_W-1:0]   rem;
  logic               go;
  logic               legal;
  logic               clr;
  logic               shift;
  logic               last;
  logic               hit;

  assign go    = (state == IDLE) && start;
  assign legal = len_legal(len_in, MAX_LEN) && (win_in != '0);
  assign clr   = go && legal;
  assign shift = (state == SCAN) && sig_valid;
  assign last  = shift && (rem == WIN_W'(1));
  assign busy  = (state == SCAN);
  assign done  = (state == DONE);

  pattern_match_window #(
    .MAX_LEN(MAX_LEN)
  ) u_win (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .shift(shift),
    .sig  (sig),
    .pat  (pat_q),
    .len  (len_q),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = legal ? SCAN : DONE;
      SCAN: if (last)  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      rem      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
      match    <= 1'b0;
    end else begin
      match <= hit;
      if (clr) begin
        pat_q    <= pat_in;
        len_q    <= len_in;
        rem      <= win_in;
        count    <= '0;
        overflow <= 1'b0;
        err      <= 1'b0;
      end else if (go) begin
        count    <= '0;
        overflow <= 1'b0;
        err      <= 1'b1;
      end else begin
        if (shift && rem != '0)
          rem <= rem - WIN_W'(1);
        // saturate instead of wrapping; overflow records the lost match
        if (hit) begin
          if (count != '1) count <= count + CNT_W'(1);
          else             overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: queue-based reference model checked each
// cycle, directed scenarios with literal results, then random jobs.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pat_in = '0;
  logic [3:0]  len_in = '0;
  logic [15:0] win_in = '0;
  logic        sig = 1'b0;
  logic        sig_valid = 1'b0;
  logic        busy, done, err, match, overflow;
  logic [7:0]  count;

  pattern_scan_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pat_in   (pat_in),
    .len_in   (len_in),
    .win_in   (win_in),
    .sig      (sig),
    .sig_valid(sig_valid),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .match    (match),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: job phase 0 idle, 1 scanning, 2 finished
  int   ph = 0;
  bit   mv = 0;
  bit   [7:0] mpat;
  int   mlen, mrem, mn;
  bit   mq[$];
  bit   e_err = 0, e_match = 0;

  function automatic bit model_hit();
    if (mq.size() < mlen) return 0;
    for (int i = 0; i < mlen; i++)
      if (mq[mq.size() - 1 - i] != mpat[i]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; mn = 0; e_err = 0; e_match = 0; mv = 1;
      mq.delete();
    end else begin
      e_match = 0;
      case (ph)
        0: if (start) begin
          mn = 0;
          if (len_in >= 1 && len_in <= 8 && win_in != 0) begin
            mpat = pat_in; mlen = int'(len_in); mrem = int'(win_in);
            mq.delete(); e_err = 0; ph = 1;
          end else begin
            e_err = 1; ph = 2;
          end
        end
        1: if (sig_valid) begin
          mq.push_back(sig);
          if (mq.size() > 8) void'(mq.pop_front());
          if (model_hit()) begin mn++; e_match = 1; end
          mrem--;
          if (mrem == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  int nbusy = 0, nmatch = 0;

  always @(negedge clk) begin
    if (busy)  nbusy++;
    if (match) nmatch++;
    if (mv) begin
      chk("busy", busy, ph == 1);
      chk("done", done, ph == 2);
      chk("err", err, e_err);
      chk("match", match, e_match);
      chk("count", count, mn > 255 ? 255 : mn);
      chk("overflow", overflow, mn > 255);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_job(input logic [7:0] p, input int l, input int w);
    tick();
    start = 1'b1; pat_in = p; len_in = 4'(l); win_in = 16'(w);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit b, input int gap);
    repeat (gap) tick();
    sig_valid = 1'b1; sig = b;
    tick();
    sig_valid = 1'b0; sig = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got 0 expected done=1 at %0t", $time);
    end
  endtask

  bit s2[10] = '{1,0,0,1,0,1,0,0,1,0};
  bit s3[5]  = '{1,0,1,0,1};
  bit s6[12] = '{1,1,0,1,1,0,1,1,0,0,0,0};
  bit s7[6]  = '{0,1,0,1,0,1};
  int b0, m0, l, w;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_match", match, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    b0 = nbusy; m0 = nmatch;
    start_job(8'b10010, 5, 10);
    foreach (s2[i]) feed(s2[i], 0);
    wait_done();
    chk("t2_match_with_done", match, 1);
    tick();
    chk("t2_count", count, 2);
    chk("t2_busy_cycles", nbusy - b0, 10);
    chk("t2_match_pulses", nmatch - m0, 2);

    start_job(8'b101, 3, 5);
    foreach (s3[i]) feed(s3[i], i == 0 ? 0 : 1);
    wait_done();
    chk("t3_count", count, 2);

    start_job(8'b1, 1, 300);
    repeat (300) feed(1'b1, 0);
    wait_done();
    chk("t4_count", count, 255);
    chk("t4_ovf", overflow, 1);

    b0 = nbusy;
    start_job(8'h5, 0, 10);
    @(negedge clk);
    chk("t5a_done", done, 1);
    chk("t5a_err", err, 1);
    chk("t5a_count", count, 0);
    start_job(8'h5, 3, 0);
    @(negedge clk);
    chk("t5b_done", done, 1);
    chk("t5b_err", err, 1);
    chk("t5_busy_cycles", nbusy - b0, 0);
    start_job(8'b11, 2, 4);
    @(negedge clk);
    chk("t5c_err_cleared", err, 0);
    chk("t5c_busy", busy, 1);
    repeat (4) feed(1'b1, 0);
    wait_done();
    chk("t5c_count", count, 3);

    start_job(8'b110, 3, 12);
    for (int i = 0; i < 6; i++) feed(s6[i], 0);
    start = 1'b1; pat_in = 8'hFF; len_in = 4'd1; win_in = 16'd2;
    feed(s6[6], 0);
    start = 1'b0;
    for (int i = 7; i < 12; i++) feed(s6[i], 0);
    wait_done();
    chk("t6_count", count, 3);

    start_job(8'b1, 1, 20);
    repeat (5) feed(1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6r_busy", busy, 0);
    chk("t6r_count", count, 0);
    chk("t6r_match", match, 0);
    start_job(8'b01, 2, 6);
    foreach (s7[i]) feed(s7[i], 0);
    wait_done();
    chk("t6r_fresh_count", count, 3);

    repeat (25) begin
      l = $urandom_range(1, 8);
      w = $urandom_range(1, 40);
      start_job(8'($urandom), l, w);
      repeat (w) feed(1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
      wait_done();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
